// File: rtl/fp_div_if.sv
// fp_div_if: operand/result handshake bundle for the fp_div fixed-point divider.
//   start       request, sampled only while the divider is idle
//   Din0/Din1   signed dividend/divisor, captured on the accepting edge
//   busy        high while a division is in progress
//   done        one-cycle pulse; Dout and flags valid
//   Dout        signed quotient, held until the next done
//   div_by_zero divisor was zero (valid with done)
//   overflow    result saturated (valid with done)
interface fp_div_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  start;
  logic [DATA_WIDTH-1:0] Din0;
  logic [DATA_WIDTH-1:0] Din1;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] Dout;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output start, Din0, Din1,
    input  busy, done, Dout, div_by_zero, overflow
  );

  modport slave (
    input  start, Din0, Din1,
    output busy, done, Dout, div_by_zero, overflow
  );
endinterface

// File: rtl/fp_div.sv
// fp_div: sequential signed fixed-point divider, Q(INTEGER_BITS).(FRACTIONAL_BITS).
// Radix-2 restoring division, one quotient bit per clock, saturating result.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fp_div_if slave: start/Din0/Din1 in, busy/done/Dout/div_by_zero/overflow out
module fp_div #(
  parameter int FRACTIONAL_BITS = 56,
  parameter int DATA_WIDTH      = 64,
  parameter int INTEGER_BITS    = DATA_WIDTH - FRACTIONAL_BITS
) (
  input  logic  clk,
  input  logic  rst_n,
  fp_div_if.slave bus
);
  localparam int W     = DATA_WIDTH;
  // Dividend is |Din0| << FRACTIONAL_BITS: DATA_WIDTH + FRACTIONAL_BITS bits.
  localparam int Q     = INTEGER_BITS + 2 * FRACTIONAL_BITS;
  localparam int CNT_W = $clog2(Q + 1);
  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MAX = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic             zero_div_q, zero_div_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic [W-1:0]     divisor_q, divisor_d;
  logic [Q-1:0]     work_q, work_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     dout_q, dout_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  logic [W-1:0] mag0, mag1;
  logic [W:0]   rem_shift;
  logic         pos_ovf, neg_ovf;

  always_comb begin
    // Two's-complement negation maps the most negative value onto 2^(W-1).
    mag0      = bus.Din0[W-1] ? -bus.Din0 : bus.Din0;
    mag1      = bus.Din1[W-1] ? -bus.Din1 : bus.Din1;
    rem_shift = {rem_q, work_q[Q-1]};
    pos_ovf   = |work_q[Q-1:W-1];
    neg_ovf   = (|work_q[Q-1:W]) || (work_q[W-1] && (|work_q[W-2:0]));

    state_d    = state_q;
    sign_d     = sign_q;
    zero_div_d = zero_div_q;
    dvd_neg_d  = dvd_neg_q;
    divisor_d  = divisor_q;
    work_d     = work_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    done_d     = 1'b0;
    dz_d       = 1'b0;
    ovf_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d     = bus.Din0[W-1] ^ bus.Din1[W-1];
          dvd_neg_d  = bus.Din0[W-1];
          zero_div_d = (bus.Din1 == '0);
          divisor_d  = mag1;
          work_d     = {mag0, {FRACTIONAL_BITS{1'b0}}};
          rem_d      = '0;
          cnt_d      = CNT_W'(Q);
          state_d    = (bus.Din1 == '0) ? FIN : CALC;
        end
      end
      CALC: begin
        // Dividend shifts out of the top while quotient bits enter at the bottom,
        // so work_q holds the quotient magnitude after the last step.
        if (rem_shift >= {1'b0, divisor_q}) begin
          rem_d  = W'(rem_shift - {1'b0, divisor_q});
          work_d = {work_q[Q-2:0], 1'b1};
        end else begin
          rem_d  = rem_shift[W-1:0];
          work_d = {work_q[Q-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (zero_div_q) begin
          dout_d = dvd_neg_q ? NEG_MAX : POS_MAX;
          dz_d   = 1'b1;
        end else if (!sign_q) begin
          dout_d = pos_ovf ? POS_MAX : work_q[W-1:0];
          ovf_d  = pos_ovf;
        end else begin
          dout_d = neg_ovf ? NEG_MAX : -work_q[W-1:0];
          ovf_d  = neg_ovf;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      zero_div_q <= 1'b0;
      dvd_neg_q  <= 1'b0;
      divisor_q  <= '0;
      work_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      zero_div_q <= zero_div_d;
      dvd_neg_q  <= dvd_neg_d;
      divisor_q  <= divisor_d;
      work_q     <= work_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.Dout        = dout_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ovf_q;
endmodule
